// File: rtl/param_rs_pkg.sv
// -----------------------------------------------------------------------------
// param_rs_pkg
// Shared ISA package for the parameterised reservation station.
// Provides the default parameter constants, the dispatch/issue packet type
// (rs_packet_t) and the stored entry type (rs_entry_t).
// The packet fields are sized from the package constants, so the param_rs
// parameters TAG_W and FU_NUM are expected to keep these default values.
// -----------------------------------------------------------------------------
package param_rs_pkg;

  localparam int RS_DEPTH_D       = 8;
  localparam int DISPATCH_WIDTH_D = 2;
  localparam int ISSUE_WIDTH_D    = 2;
  localparam int CDB_WIDTH_D      = 2;
  localparam int FU_NUM_D         = 5;
  localparam int TAG_W_D          = 6;
  localparam int PAYLOAD_W        = 16;

  typedef struct packed {
    logic [TAG_W_D-1:0]   dest_tag;
    logic [TAG_W_D-1:0]   src1_tag;
    logic [TAG_W_D-1:0]   src2_tag;
    logic                 src1_rdy;
    logic                 src2_rdy;
    logic [FU_NUM_D-1:0]  fu_mask;
    logic [PAYLOAD_W-1:0] payload;
  } rs_packet_t;

  typedef struct packed {
    logic       valid;
    rs_packet_t pkt;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// -----------------------------------------------------------------------------
// rs_age_select
// Oldest-first issue selection with per-port functional-unit assignment.
// Ports:
//   age      : age[r][c] = 1 means entry r is older than entry c
//   eligible : entry valid with both sources ready
//   fu_cand  : per-entry fu_mask & fu_ready
//   grant    : per issue port, one-hot entry grant (all zero = no issue)
//   fu_sel   : per issue port, one-hot FU chosen for the granted entry
// Port p takes the oldest eligible entry that still has a free candidate FU
// after ports 0..p-1 claimed theirs; it gets the lowest such FU.
// -----------------------------------------------------------------------------
module rs_age_select #(
  parameter int RS_DEPTH    = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int FU_NUM      = 5
) (
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age,
  input  logic [RS_DEPTH-1:0]                eligible,
  input  logic [RS_DEPTH-1:0][FU_NUM-1:0]    fu_cand,
  output logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0] grant,
  output logic [ISSUE_WIDTH-1:0][FU_NUM-1:0]   fu_sel
);

  logic [RS_DEPTH-1:0] remain_s;
  logic [RS_DEPTH-1:0] cand_s;
  logic [FU_NUM-1:0]   fu_free_s;
  logic [FU_NUM-1:0]   pick_s;
  logic                blocked_s;
  logic                found_s;

  // Port-by-port oldest selection, removing granted entries and claimed FUs
  always_comb begin
    grant     = '0;
    fu_sel    = '0;
    remain_s  = eligible;
    fu_free_s = '1;
    cand_s    = '0;
    pick_s    = '0;
    blocked_s = 1'b0;
    found_s   = 1'b0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      for (int e = 0; e < RS_DEPTH; e++) begin
        cand_s[e] = remain_s[e] & (|(fu_cand[e] & fu_free_s));
      end
      found_s = 1'b0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        // An entry is oldest when no other candidate is older than it
        blocked_s = 1'b0;
        for (int r = 0; r < RS_DEPTH; r++) begin
          blocked_s = blocked_s | (cand_s[r] & age[r][e]);
        end
        if (cand_s[e] && !blocked_s && !found_s) begin
          found_s     = 1'b1;
          grant[p][e] = 1'b1;
          pick_s      = fu_cand[e] & fu_free_s;
          fu_sel[p]   = pick_s & (~pick_s + {{(FU_NUM-1){1'b0}}, 1'b1});
        end else begin
          grant[p][e] = 1'b0;
        end
      end
      fu_free_s = fu_free_s & ~fu_sel[p];
      remain_s  = remain_s & ~grant[p];
    end
  end

endmodule

// File: rtl/param_rs.sv
// -----------------------------------------------------------------------------
// param_rs
// Parameterised reservation station: dispatch into lowest free entries,
// CDB wakeup, oldest-first multi-port issue with FU assignment, flush.
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   defined   : selection also sees this cycle's CDB wakeups
//   undefined : selection uses registered ready bits only
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   disp_valid/packet  : dispatch lanes; accepted only while disp_ready
//   disp_ready         : free_count >= DISPATCH_WIDTH
//   cdb_valid/cdb_tag  : completion broadcasts
//   fu_ready           : FU k can accept an instruction this cycle
//   flush              : squash everything at the next edge
//   iss_valid/packet   : registered issue ports (packet zero when idle)
//   iss_fu_sel         : registered one-hot target FU per issue port
//   free_count         : number of invalid entries (registered state)
// -----------------------------------------------------------------------------
module param_rs
  import param_rs_pkg::*;
#(
  parameter int RS_DEPTH       = RS_DEPTH_D,
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_D,
  parameter int ISSUE_WIDTH    = ISSUE_WIDTH_D,
  parameter int CDB_WIDTH      = CDB_WIDTH_D,
  parameter int FU_NUM         = FU_NUM_D,
  parameter int TAG_W          = TAG_W_D
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DISPATCH_WIDTH-1:0]             disp_valid,
  input  rs_packet_t [DISPATCH_WIDTH-1:0]       disp_packet,
  output logic                                  disp_ready,
  input  logic [CDB_WIDTH-1:0]                  cdb_valid,
  input  logic [CDB_WIDTH-1:0][TAG_W-1:0]       cdb_tag,
  input  logic [FU_NUM-1:0]                     fu_ready,
  input  logic                                  flush,
  output logic [ISSUE_WIDTH-1:0]                iss_valid,
  output rs_packet_t [ISSUE_WIDTH-1:0]          iss_packet,
  output logic [ISSUE_WIDTH-1:0][FU_NUM-1:0]    iss_fu_sel,
  output logic [$clog2(RS_DEPTH+1)-1:0]         free_count
);

  localparam int CNT_W = $clog2(RS_DEPTH+1);

  rs_entry_t [RS_DEPTH-1:0]               ent_q, ent_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]      age_q, age_d;
  logic [ISSUE_WIDTH-1:0]                 iss_valid_q, iss_valid_d;
  rs_packet_t [ISSUE_WIDTH-1:0]           iss_packet_q, iss_packet_d;
  logic [ISSUE_WIDTH-1:0][FU_NUM-1:0]     iss_fu_sel_q, iss_fu_sel_d;

  logic [RS_DEPTH-1:0]                    hit1_s, hit2_s;
  logic [RS_DEPTH-1:0]                    sel_r1_s, sel_r2_s;
  logic [RS_DEPTH-1:0]                    eligible_s;
  logic [RS_DEPTH-1:0][FU_NUM-1:0]        fu_cand_s;
  logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]   grant_s;
  logic [ISSUE_WIDTH-1:0][FU_NUM-1:0]     fu_sel_s;
  logic [RS_DEPTH-1:0]                    free_vec_s;
  logic [CNT_W-1:0]                       free_cnt_s;
  logic                                   placed_s;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [CDB_WIDTH-1:0] v,
                                   input logic [CDB_WIDTH-1:0][TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < CDB_WIDTH; j++) begin
      hit = hit | (v[j] & (t[j] == tag));
    end
    return hit;
  endfunction

  // Free count and dispatch readiness from registered entry state only
  always_comb begin
    free_cnt_s = '0;
    for (int e = 0; e < RS_DEPTH; e++) begin
      free_cnt_s = free_cnt_s + CNT_W'(!ent_q[e].valid);
    end
  end

  assign free_count = free_cnt_s;
  assign disp_ready = (free_cnt_s >= CNT_W'(DISPATCH_WIDTH));

  // Wakeup matches and eligibility seen by the selector
  always_comb begin
    hit1_s     = '0;
    hit2_s     = '0;
    sel_r1_s   = '0;
    sel_r2_s   = '0;
    eligible_s = '0;
    fu_cand_s  = '0;
    for (int e = 0; e < RS_DEPTH; e++) begin
      hit1_s[e] = cdb_hit(ent_q[e].pkt.src1_tag, cdb_valid, cdb_tag);
      hit2_s[e] = cdb_hit(ent_q[e].pkt.src2_tag, cdb_valid, cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      sel_r1_s[e] = ent_q[e].pkt.src1_rdy | hit1_s[e];
      sel_r2_s[e] = ent_q[e].pkt.src2_rdy | hit2_s[e];
`else
      sel_r1_s[e] = ent_q[e].pkt.src1_rdy;
      sel_r2_s[e] = ent_q[e].pkt.src2_rdy;
`endif
      fu_cand_s[e]  = ent_q[e].pkt.fu_mask & fu_ready;
      eligible_s[e] = ent_q[e].valid & sel_r1_s[e] & sel_r2_s[e];
    end
  end

  rs_age_select #(
    .RS_DEPTH    (RS_DEPTH),
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .FU_NUM      (FU_NUM)
  ) u_age_select (
    .age      (age_q),
    .eligible (eligible_s),
    .fu_cand  (fu_cand_s),
    .grant    (grant_s),
    .fu_sel   (fu_sel_s)
  );

  // Next state: wakeup, issue/invalidate, dispatch allocation, flush override
  always_comb begin
    ent_d        = ent_q;
    age_d        = age_q;
    iss_valid_d  = '0;
    iss_packet_d = '0;
    iss_fu_sel_d = '0;
    free_vec_s   = '0;
    placed_s     = 1'b0;

    for (int e = 0; e < RS_DEPTH; e++) begin
      ent_d[e].pkt.src1_rdy = ent_q[e].pkt.src1_rdy | hit1_s[e];
      ent_d[e].pkt.src2_rdy = ent_q[e].pkt.src2_rdy | hit2_s[e];
    end

    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      iss_valid_d[p]  = |grant_s[p];
      iss_fu_sel_d[p] = fu_sel_s[p];
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (grant_s[p][e]) begin
          iss_packet_d[p]          = ent_q[e].pkt;
          iss_packet_d[p].src1_rdy = sel_r1_s[e];
          iss_packet_d[p].src2_rdy = sel_r2_s[e];
          ent_d[e].valid           = 1'b0;
        end else begin
          ent_d[e].valid = ent_d[e].valid;
        end
      end
    end

    // Lanes in order take the lowest free slots; each new entry becomes
    // youngest, so a later lane automatically ends up younger than an earlier one
    if (disp_ready) begin
      for (int e = 0; e < RS_DEPTH; e++) begin
        free_vec_s[e] = ~ent_q[e].valid;
      end
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        placed_s = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++) begin
          if (disp_valid[l] && !placed_s && free_vec_s[e]) begin
            placed_s              = 1'b1;
            free_vec_s[e]         = 1'b0;
            ent_d[e].valid        = 1'b1;
            ent_d[e].pkt          = disp_packet[l];
            ent_d[e].pkt.src1_rdy = disp_packet[l].src1_rdy |
                                    cdb_hit(disp_packet[l].src1_tag, cdb_valid, cdb_tag);
            ent_d[e].pkt.src2_rdy = disp_packet[l].src2_rdy |
                                    cdb_hit(disp_packet[l].src2_tag, cdb_valid, cdb_tag);
            age_d[e] = '0;
            for (int r = 0; r < RS_DEPTH; r++) begin
              age_d[r][e] = (r != e);
            end
          end else begin
            placed_s = placed_s;
          end
        end
      end
    end else begin
      free_vec_s = '0;
    end

    if (flush) begin
      ent_d        = '0;
      age_d        = '0;
      iss_valid_d  = '0;
      iss_packet_d = '0;
      iss_fu_sel_d = '0;
    end else begin
      ent_d = ent_d;
    end
  end

  // State and issue-output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q        <= '0;
      age_q        <= '0;
      iss_valid_q  <= '0;
      iss_packet_q <= '0;
      iss_fu_sel_q <= '0;
    end else begin
      ent_q        <= ent_d;
      age_q        <= age_d;
      iss_valid_q  <= iss_valid_d;
      iss_packet_q <= iss_packet_d;
      iss_fu_sel_q <= iss_fu_sel_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_packet = iss_packet_q;
  assign iss_fu_sel = iss_fu_sel_q;

endmodule

// File: tb/tb_param_rs.sv
// -----------------------------------------------------------------------------
// tb_param_rs
// Scoreboard bench for param_rs. A reference model keeps the entries as an
// age-ordered queue; each cycle it predicts the issues and pushes them into
// an expectation queue that an independent monitor pops against the DUT.
// Honours RS_WAKEUP_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_param_rs;
  import param_rs_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int IW    = 2;
  localparam int CW    = 2;
  localparam int FN    = 5;
  localparam int TW    = 6;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clock;
  logic                  reset;
  logic                  flush;
  logic [DW-1:0]         disp_valid;
  rs_packet_t [DW-1:0]   disp_packet;
  logic                  disp_ready;
  logic [CW-1:0]         cdb_valid;
  logic [CW-1:0][TW-1:0] cdb_tag;
  logic [FN-1:0]         fu_ready;
  logic [IW-1:0]         iss_valid;
  rs_packet_t [IW-1:0]   iss_packet;
  logic [IW-1:0][FN-1:0] iss_fu_sel;
  logic [3:0]            free_count;

  // values applied at the next negedge
  logic                  n_reset, n_flush;
  logic [DW-1:0]         n_dv;
  rs_packet_t [DW-1:0]   n_dp;
  logic [CW-1:0]         n_cv;
  logic [CW-1:0][TW-1:0] n_ct;
  logic [FN-1:0]         n_fr;

  typedef struct {
    int            due;
    int            port;
    rs_packet_t    pkt;
    logic [FN-1:0] fu;
  } exp_t;

  exp_t       exp_q[$];
  rs_packet_t m_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         pay_id = 1;

  param_rs dut (
    .clock      (clock),
    .reset      (reset),
    .disp_valid (disp_valid),
    .disp_packet(disp_packet),
    .disp_ready (disp_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .fu_ready   (fu_ready),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_packet (iss_packet),
    .iss_fu_sel (iss_fu_sel),
    .free_count (free_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit hit(input logic [TW-1:0] tag);
    for (int j = 0; j < CW; j++) begin
      if (cdb_valid[j] && cdb_tag[j] == tag) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic rs_packet_t mk(input int d, input int s1, input int s2,
                                    input bit r1, input bit r2, input logic [FN-1:0] m);
    rs_packet_t p;
    p.dest_tag = 6'(d);
    p.src1_tag = 6'(s1);
    p.src2_tag = 6'(s2);
    p.src1_rdy = r1;
    p.src2_rdy = r2;
    p.fu_mask  = m;
    p.payload  = 16'(pay_id);
    pay_id++;
    return p;
  endfunction

  // One clock edge of the reference model, using the inputs now applied
  task automatic model_step();
    rs_packet_t    nq[$];
    bit            sel[$];
    logic [FN-1:0] avail;
    int            size0;
    rs_packet_t    p;
    exp_t          e;
    if (reset || flush) begin
      m_q.delete();
      return;
    end
    size0 = m_q.size();
    avail = fu_ready;
    for (int i = 0; i < size0; i++) sel.push_back(1'b0);
    for (int port = 0; port < IW; port++) begin
      for (int i = 0; i < size0; i++) begin
        bit r1, r2;
        logic [FN-1:0] c;
        r1 = m_q[i].src1_rdy || (BYP && hit(m_q[i].src1_tag));
        r2 = m_q[i].src2_rdy || (BYP && hit(m_q[i].src2_tag));
        c  = m_q[i].fu_mask & avail;
        if (!sel[i] && r1 && r2 && c != '0) begin
          int k;
          k = 0;
          while (!c[k]) k++;
          e.due = cyc + 1;
          e.port = port;
          e.pkt = m_q[i];
          e.pkt.src1_rdy = 1'b1;
          e.pkt.src2_rdy = 1'b1;
          e.fu = '0;
          e.fu[k] = 1'b1;
          exp_q.push_back(e);
          avail[k] = 1'b0;
          sel[i] = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < size0; i++) begin
      if (!sel[i]) begin
        p = m_q[i];
        p.src1_rdy = p.src1_rdy | hit(p.src1_tag);
        p.src2_rdy = p.src2_rdy | hit(p.src2_tag);
        nq.push_back(p);
      end
    end
    if (DEPTH - size0 >= DW) begin
      for (int l = 0; l < DW; l++) begin
        if (disp_valid[l]) begin
          p = disp_packet[l];
          p.src1_rdy = p.src1_rdy | hit(p.src1_tag);
          p.src2_rdy = p.src2_rdy | hit(p.src2_tag);
          nq.push_back(p);
        end
      end
    end
    m_q = nq;
  endtask

  task automatic tick();
    @(negedge clock);
    check("free_count", free_count, DEPTH - m_q.size());
    check("disp_ready", disp_ready, (DEPTH - m_q.size()) >= DW);
    reset       = n_reset;
    flush       = n_flush;
    disp_valid  = n_dv;
    disp_packet = n_dp;
    cdb_valid   = n_cv;
    cdb_tag     = n_ct;
    fu_ready    = n_fr;
    model_step();
    n_reset = 1'b0;
    n_flush = 1'b0;
    n_dv    = '0;
    n_cv    = '0;
  endtask

  // Monitor: compare each presented issue against the expectation queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      for (int p = 0; p < IW; p++) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missed_issue: port %0d payload %0h due cycle %0d not seen", e.port, e.pkt.payload, e.due);
        end
        if (iss_valid[p]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_issue: port %0d payload %0h cycle %0d", p, iss_packet[p].payload, cyc);
          end else begin
            e = exp_q.pop_front();
            check("iss_cycle", cyc, e.due);
            check("iss_port", p, e.port);
            check("iss_packet", iss_packet[p], e.pkt);
            check("iss_fu_sel", iss_fu_sel[p], e.fu);
          end
        end else begin
          check("idle_packet", iss_packet[p], 64'd0);
          check("idle_fu_sel", iss_fu_sel[p], 64'd0);
          if (exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].port == p) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_issue: port %0d payload %0h cycle %0d", p, e.pkt.payload, cyc);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; disp_valid = '0; disp_packet = '0;
    cdb_valid = '0; cdb_tag = '0; fu_ready = '1;
    n_reset = 1'b1; n_flush = 1'b0; n_dv = '0; n_dp = '0; n_cv = '0; n_ct = '0; n_fr = '1;

    // reset
    tick();
    tick();
    check("reset_iss_valid", iss_valid, 64'd0);
    check("reset_free_count", free_count, 64'd8);

    // ready operands, two lanes, two FUs
    n_dv = 2'b11;
    n_dp[0] = mk(1, 2, 3, 1'b1, 1'b1, 5'b00011);
    n_dp[1] = mk(4, 5, 6, 1'b1, 1'b1, 5'b00011);
    tick();
    repeat (3) tick();

    // wakeup latency on tag 5
    n_dv = 2'b01;
    n_dp[0] = mk(10, 5, 7, 1'b0, 1'b1, 5'b00001);
    tick();
    repeat (2) tick();
    n_cv = 2'b01; n_ct[0] = 6'd5;
    tick();
    repeat (3) tick();

    // age ordering: A..H pending on tag 9, then one wakeup
    for (int i = 0; i < 4; i++) begin
      n_dv = 2'b11;
      n_dp[0] = mk(20 + 2 * i, 9, 9, 1'b0, 1'b0, 5'b00011);
      n_dp[1] = mk(21 + 2 * i, 9, 9, 1'b0, 1'b0, 5'b00011);
      tick();
    end
    n_dv = 2'b11;
    n_dp[0] = mk(40, 40, 40, 1'b0, 1'b0, 5'b00001);
    n_dp[1] = mk(41, 40, 40, 1'b0, 1'b0, 5'b00001);
    n_cv = 2'b01; n_ct[0] = 6'd9;
    tick();
    repeat (6) tick();

    // FU contention: single FU 3 ready
    n_fr = 5'b01000;
    n_dv = 2'b11;
    n_dp[0] = mk(50, 0, 0, 1'b1, 1'b1, 5'b01000);
    n_dp[1] = mk(51, 0, 0, 1'b1, 1'b1, 5'b01000);
    tick();
    n_dv = 2'b01;
    n_dp[0] = mk(52, 0, 0, 1'b1, 1'b1, 5'b01000);
    tick();
    repeat (4) tick();
    n_fr = '1;
    repeat (2) tick();

    // flush beats dispatch, CDB and selection
    n_fr = 5'b00000;
    n_dv = 2'b11;
    n_dp[0] = mk(60, 33, 1, 1'b0, 1'b1, 5'b00001);
    n_dp[1] = mk(61, 1, 1, 1'b1, 1'b1, 5'b00010);
    tick();
    n_fr = '1;
    n_flush = 1'b1;
    n_dv = 2'b11;
    n_dp[0] = mk(62, 1, 1, 1'b1, 1'b1, 5'b00001);
    n_dp[1] = mk(63, 1, 1, 1'b1, 1'b1, 5'b00001);
    n_cv = 2'b01; n_ct[0] = 6'd33;
    tick();
    tick();
    check("flush_free_count", free_count, 64'd8);
    check("flush_iss_valid", iss_valid, 64'd0);

    // reset mid-operation abandons selection
    n_dv = 2'b11;
    n_dp[0] = mk(70, 1, 1, 1'b1, 1'b1, 5'b00001);
    n_dp[1] = mk(71, 1, 1, 1'b1, 1'b1, 5'b00010);
    tick();
    n_reset = 1'b1;
    tick();
    tick();
    check("midreset_iss_valid", iss_valid, 64'd0);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      n_dv = 2'($urandom_range(0, 3));
      for (int l = 0; l < DW; l++) begin
        n_dp[l] = mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(1, 31)));
      end
      n_cv = 2'($urandom_range(0, 3));
      n_ct[0] = 6'($urandom_range(0, 7));
      n_ct[1] = 6'($urandom_range(0, 7));
      n_fr = 5'($urandom_range(0, 31));
      n_flush = ($urandom_range(0, 63) == 0);
      n_reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    // drain: wake every tag and let everything issue
    n_fr = '1;
    for (int t = 0; t < 4; t++) begin
      n_cv = 2'b11;
      n_ct[0] = 6'(2 * t);
      n_ct[1] = 6'(2 * t + 1);
      tick();
    end
    repeat (10) tick();
    check("drain_expect_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
